muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state encoding and the default datapath width.
package muldiv_pkg;

  localparam int MULDIV_XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// sharing one 2*XLEN accumulator, XLEN CALC cycles followed by a sign-fix cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            wren_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] apply_sign_wide(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2:0]          op_q;
  logic                neg_q;
  logic                rem_neg_q;
  logic [XLEN-1:0]     result_q;
  logic [4:0]          rd_q;

  logic                accept;
  logic                is_div;
  logic                a_signed, b_signed;
  logic                a_neg, b_neg;
  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     special_res;

  // Capture-time decode: signedness, magnitudes and the early-exit division cases
  assign accept   = (state_q == IDLE) && start_i;
  assign is_div   = op_i[2];
  assign a_signed = (op_i != OP_MULHU) && (op_i != OP_DIVU) && (op_i != OP_REMU);
  assign b_signed = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign rs1_s    = rs1_i;
  assign rs2_s    = rs2_i;
  assign a_neg    = a_signed && (rs1_s < 0);
  assign b_neg    = b_signed && (rs2_s < 0);
  assign a_mag    = apply_sign(rs1_i, a_neg);
  assign b_mag    = apply_sign(rs2_i, b_neg);

  assign div_zero = is_div && (rs2_i == '0);
  assign div_ovf  = is_div && !op_i[0] && (rs1_i == XLEN_MIN) && (rs2_i == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = op_i[1] ? rs1_i : '1;
    else if (div_ovf) special_res = op_i[1] ? '0 : XLEN_MIN;
  end

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_trial;
  logic [2*XLEN-1:0]   div_next;

  // One iteration: multiply adds into the high half then shifts right;
  // divide shifts left and subtracts the divisor when it fits
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_next  = div_trial[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix, rem_fix;
  logic [XLEN-1:0]     fix_res;

  assign prod_fix = apply_sign_wide(acc_q, neg_q);
  assign quot_fix = apply_sign(acc_q[XLEN-1:0], neg_q);
  assign rem_fix  = apply_sign(acc_q[2*XLEN-1:XLEN], rem_neg_q);

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quot_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b1;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = special ? DONE : CALC;
      end
      CALC: if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; reset aborts any operation in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
        rd_q  <= rd_i;
        if (special) result_q <= special_res;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == FIX) result_q <= fix_res;
    end
  end

  // Datapath registers; always loaded on accept before use
  always_ff @(posedge clk_i) begin
    if (accept) begin
      acc_q     <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
      opnd_q    <= is_div ? b_mag : a_mag;
      op_q      <= op_i;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
    end else if (state_q == CALC) begin
      acc_q <= op_q[2] ? div_next : mul_next;
    end
  end

  assign result_o = result_q;
  assign rd_o     = rd_q;
  assign wren_o   = done_o;

endmodule
